// File: rtl/game_clock_pkg.sv
// Shared types for the game clock: FSM state encoding, BCD digits, MM:SS helpers.
package game_clock_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StRun       = 3'd1,
    StPaused    = 3'd2,
    StPeriodEnd = 3'd3,
    StBreak     = 3'd4,
    StOver      = 3'd5
  } game_state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } mmss_t;

  // Split a seconds count (0..3599) into four BCD digits.
  function automatic mmss_t secs_to_mmss(input int unsigned secs);
    int unsigned mins;
    int unsigned rem;
    mmss_t       t;
    mins       = secs / 60;
    rem        = secs % 60;
    t.min_tens = bcd_t'(mins / 10);
    t.min_ones = bcd_t'(mins % 10);
    t.sec_tens = bcd_t'(rem / 10);
    t.sec_ones = bcd_t'(rem % 10);
    return t;
  endfunction

  function automatic mmss_t mins_to_mmss(input int unsigned mins);
    return secs_to_mmss(mins * 60);
  endfunction

endpackage

// File: rtl/mmss_bcd_downcounter.sv
// MM:SS down-counter over four BCD digits with load, decrement and end-of-count flags.
module mmss_bcd_downcounter
  import game_clock_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic [15:0] value,
  output logic        zero,
  output logic        last
);

  mmss_t cnt_q, cnt_d;

  // Next count: load wins over decrement; decrement saturates at 00:00.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && !zero) begin
      if (cnt_q.sec_ones != 4'd0) begin
        cnt_d.sec_ones = cnt_q.sec_ones - 4'd1;
      end else begin
        cnt_d.sec_ones = 4'd9;
        if (cnt_q.sec_tens != 4'd0) begin
          cnt_d.sec_tens = cnt_q.sec_tens - 4'd1;
        end else begin
          cnt_d.sec_tens = 4'd5;
          if (cnt_q.min_ones != 4'd0) begin
            cnt_d.min_ones = cnt_q.min_ones - 4'd1;
          end else begin
            cnt_d.min_ones = 4'd9;
            cnt_d.min_tens = cnt_q.min_tens - 4'd1;
          end
        end
      end
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= RESET_VAL;
    else       cnt_q <= cnt_d;
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == 16'h0000);
  assign last  = (cnt_q == 16'h0001);

endmodule

// File: rtl/game_period_sequencer.sv
// Game clock sequencer: period/break countdown, pause/resume, buzzer and game-over.
module game_period_sequencer
  import game_clock_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned PERIOD_MIN  = 12,
  parameter int unsigned BREAK_SEC   = 120,
  parameter int unsigned NUM_PERIODS = 4,
  parameter int unsigned BUZZ_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_game,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] period,
  output logic [2:0] state,
  output logic       running,
  output logic       buzzer,
  output logic       game_over
);

  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BUZZ_W = $clog2(BUZZ_CYCLES + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [BUZZ_W-1:0] BUZZ_LOAD   = BUZZ_W'(BUZZ_CYCLES);
  localparam logic [15:0]       PERIOD_TIME = mins_to_mmss(PERIOD_MIN);
  localparam logic [15:0]       BREAK_TIME  = secs_to_mmss(BREAK_SEC);
  localparam logic [2:0]        LAST_PERIOD = 3'(NUM_PERIODS);

  game_state_e       state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [BUZZ_W-1:0] buzz_q, buzz_d;
  logic [2:0]        period_q, period_d;
  logic              running_q, game_over_q, buzzer_q;

  logic              tick;
  logic              load;
  logic [15:0]       load_val;
  logic              dec;
  logic [15:0]       time_val;
  logic              time_zero;
  logic              time_last;
  logic              expire;

  mmss_bcd_downcounter #(
    .RESET_VAL (PERIOD_TIME)
  ) u_time (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .value    (time_val),
    .zero     (time_zero),
    .last     (time_last)
  );

  assign tick   = ((state_q == StRun) || (state_q == StBreak)) && (pre_q == PRE_LAST);
  // A count already at zero still expires so the clock can never stall.
  assign expire = tick && (time_last || time_zero);

  // Next-state, prescaler, period and buzzer-timer logic.
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    period_d = period_q;
    buzz_d   = (buzz_q != '0) ? buzz_q - 1'b1 : buzz_q;
    load     = 1'b0;
    load_val = PERIOD_TIME;
    dec      = 1'b0;

    if (new_game) begin
      state_d  = StIdle;
      pre_d    = '0;
      period_d = 3'd1;
      buzz_d   = '0;
      load     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StRun;
            pre_d   = '0;
          end
        end
        StRun: begin
          if (pause) begin
            // The pause cycle still counts, but a due tick is deferred to resume.
            state_d = StPaused;
            if (!tick) pre_d = pre_q + 1'b1;
          end else begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            dec   = tick;
            if (expire) begin
              state_d = StPeriodEnd;
              buzz_d  = BUZZ_LOAD;
            end
          end
        end
        StPaused: begin
          if (start && !pause) state_d = StRun;
        end
        StPeriodEnd: begin
          if (period_q == LAST_PERIOD) begin
            state_d = StOver;
          end else begin
            state_d  = StBreak;
            load     = 1'b1;
            load_val = BREAK_TIME;
            pre_d    = '0;
          end
        end
        StBreak: begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          dec   = tick;
          if (expire) begin
            state_d  = StIdle;
            period_d = period_q + 3'd1;
            load     = 1'b1;
            load_val = PERIOD_TIME;
            buzz_d   = BUZZ_LOAD;
          end
        end
        StOver: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      pre_q       <= '0;
      buzz_q      <= '0;
      period_q    <= 3'd1;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
      buzzer_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      buzz_q      <= buzz_d;
      period_q    <= period_d;
      running_q   <= (state_d == StRun) || (state_d == StBreak);
      game_over_q <= (state_d == StOver);
      buzzer_q    <= (buzz_d != '0);
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = time_val;
  assign period    = period_q;
  assign state     = state_q;
  assign running   = running_q;
  assign buzzer    = buzzer_q;
  assign game_over = game_over_q;

endmodule
